// File: rtl/nvdla_sdp_unpack_arb.sv
// Group-atomic round-robin arbiter that feeds one SDP width-packer from two narrow streams.
// Data, valid and ready are combinational. Each grant lasts exactly RATIO accepted beats.
module nvdla_sdp_unpack_arb #(
    parameter int IW    = 128,
    parameter int RATIO = 4
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic [1:0]    reg2dp_src_en,
    input  logic          req0_pvld,
    output logic          req0_prdy,
    input  logic [IW-1:0] req0_data,
    input  logic          req1_pvld,
    output logic          req1_prdy,
    input  logic [IW-1:0] req1_data,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [IW-1:0] out_data,
    output logic          out_src,
    output logic          out_sop,
    output logic          out_eop
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [3:0] LAST_BEAT = 4'(RATIO - 1);

    state_t     state, state_nxt;
    logic [3:0] beat_cnt, beat_cnt_nxt;
    logic       ptr, ptr_nxt;

    logic elig0, elig1, any_elig, winner;
    logic grant, gvld, has_grant, accept;

    assign elig0 = req0_pvld & reg2dp_src_en[0];
    assign elig1 = req1_pvld & reg2dp_src_en[1];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
            ptr      <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            ptr      <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        ptr_nxt      = ptr;
        any_elig     = elig0 | elig1;
        winner       = (elig0 & elig1) ? ptr : elig1;
        grant        = 1'b0;
        gvld         = 1'b0;
        has_grant    = 1'b0;

        case (state)
            IDLE: begin
                grant     = winner;
                gvld      = any_elig;
                has_grant = any_elig;
            end
            LOCK0: begin
                grant     = 1'b0;
                gvld      = req0_pvld;
                has_grant = 1'b1;
            end
            LOCK1: begin
                grant     = 1'b1;
                gvld      = req1_pvld;
                has_grant = 1'b1;
            end
            default: ;
        endcase

        // Outputs stay quiet while reset is held so the packer never sees a beat.
        if (!nvdla_core_rstn) begin
            grant     = 1'b0;
            gvld      = 1'b0;
            has_grant = 1'b0;
        end

        accept    = gvld & out_prdy;
        out_pvld  = gvld;
        out_src   = grant;
        out_data  = grant ? req1_data : req0_data;
        req0_prdy = has_grant & ~grant & out_prdy;
        req1_prdy = has_grant &  grant & out_prdy;
        out_sop   = gvld & ((state == IDLE) | (beat_cnt == 4'd0));
        out_eop   = gvld & ((RATIO == 1) | ((state != IDLE) & (beat_cnt == LAST_BEAT)));

        case (state)
            IDLE: begin
                if (any_elig) begin
                    if (accept && (RATIO == 1)) begin
                        ptr_nxt = ~winner;
                    end else begin
                        // Lock even without an accept so a stalled beat keeps its source.
                        state_nxt    = winner ? LOCK1 : LOCK0;
                        beat_cnt_nxt = accept ? 4'd1 : 4'd0;
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (accept) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = 4'd0;
                        ptr_nxt      = (state == LOCK0);
                    end else begin
                        beat_cnt_nxt = beat_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nvdla_sdp_unpack_arb.sv
// Directed, table-driven bench for nvdla_sdp_unpack_arb with RATIO=4.
// Each table row is one clock cycle of stimulus plus the expected handshake and flag outputs.
module tb_nvdla_sdp_unpack_arb;

    localparam int IW    = 128;
    localparam int RATIO = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    src_en = 2'b11;
    logic          v0 = 1'b0, v1 = 1'b0, prdy = 1'b0;
    logic [IW-1:0] d0 = '0, d1 = '0;
    logic          p0, p1, opvld, osrc, osop, oeop;
    logic [IW-1:0] odata;

    nvdla_sdp_unpack_arb #(.IW(IW), .RATIO(RATIO)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .reg2dp_src_en  (src_en),
        .req0_pvld      (v0),
        .req0_prdy      (p0),
        .req0_data      (d0),
        .req1_pvld      (v1),
        .req1_prdy      (p1),
        .req1_data      (d1),
        .out_pvld       (opvld),
        .out_prdy       (prdy),
        .out_data       (odata),
        .out_src        (osrc),
        .out_sop        (osop),
        .out_eop        (oeop)
    );

    always #5 clk = ~clk;

    // exp = {out_pvld, req0_prdy, req1_prdy, out_src, out_sop, out_eop}
    typedef struct {
        string      tag;
        logic       rstn;
        logic [1:0] en;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       prdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input string tag, input logic r, input logic [1:0] en,
                       input logic a0, input logic [7:0] x0, input logic a1, input logic [7:0] x1,
                       input logic rdy, input logic [5:0] exp);
        vec_t v;
        v.tag = tag; v.rstn = r; v.en = en; v.v0 = a0; v.d0 = x0;
        v.v1 = a1; v.d1 = x1; v.prdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [5:0]    act;
        logic [IW-1:0] exp_data;
        logic          f;

        // Reset with traffic present: everything quiet.
        add("reset",   1'b0, 2'b11, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 6'b000000);
        add("reset",   1'b0, 2'b11, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 6'b000000);
        // Single source streaming 8 beats: two groups from src0.
        for (int k = 0; k < 8; k++)
            add("single", 1'b1, 2'b11, 1'b1, 8'(k), 1'b0, 8'hee, 1'b1,
                {4'b1100, 1'(k % 4 == 0), 1'(k % 4 == 3)});
        // Both always valid; ptr now favours src1.
        for (int k = 0; k < 8; k++) begin
            f = (k < 4);
            add("both", 1'b1, 2'b11, 1'b1, 8'(8'h10 + k), 1'b1, 8'(8'h20 + k), 1'b1,
                {1'b1, ~f, f, f, 1'(k % 4 == 0), 1'(k % 4 == 3)});
        end
        // Backpressure on src1's first beat while src0 rises.
        add("bp_stall", 1'b1, 2'b11, 1'b0, 8'h30, 1'b1, 8'h40, 1'b0, 6'b100110);
        add("bp_stall", 1'b1, 2'b11, 1'b1, 8'h30, 1'b1, 8'h40, 1'b0, 6'b100110);
        add("bp_stall", 1'b1, 2'b11, 1'b1, 8'h30, 1'b1, 8'h40, 1'b0, 6'b100110);
        add("bp_accept", 1'b1, 2'b11, 1'b1, 8'h30, 1'b1, 8'h40, 1'b1, 6'b101110);
        for (int k = 1; k < 4; k++)
            add("bp_rest", 1'b1, 2'b11, 1'b1, 8'h30, 1'b1, 8'(8'h40 + k), 1'b1,
                {5'b10110, 1'(k == 3)});
        // Mid-group gap on src0 with src1 waiting.
        for (int k = 0; k < 2; k++)
            add("gap_pre", 1'b1, 2'b11, 1'b1, 8'(8'h50 + k), 1'b1, 8'h60, 1'b1,
                {4'b1100, 1'(k == 0), 1'b0});
        for (int k = 0; k < 5; k++)
            add("gap_hole", 1'b1, 2'b11, 1'b0, 8'h52, 1'b1, 8'h60, 1'b1, 6'b010000);
        for (int k = 2; k < 4; k++)
            add("gap_post", 1'b1, 2'b11, 1'b1, 8'(8'h50 + k), 1'b1, 8'h60, 1'b1,
                {5'b11000, 1'(k == 3)});
        for (int k = 0; k < 4; k++)
            add("gap_src1", 1'b1, 2'b11, 1'b0, 8'h58, 1'b1, 8'(8'h60 + k), 1'b1,
                {4'b1011, 1'(k == 0), 1'(k == 3)});
        // Mask 01: src0 wins twice in a row; switching to 10 mid-group is ignored.
        for (int k = 0; k < 4; k++)
            add("mask01", 1'b1, 2'b01, 1'b1, 8'(8'h70 + k), 1'b1, 8'h78, 1'b1,
                {4'b1100, 1'(k == 0), 1'(k == 3)});
        for (int k = 0; k < 4; k++)
            add("mask_chg", 1'b1, (k == 0) ? 2'b01 : 2'b10, 1'b1, 8'(8'h74 + k), 1'b1, 8'h7c, 1'b1,
                {4'b1100, 1'(k == 0), 1'(k == 3)});
        add("mask10", 1'b1, 2'b10, 1'b1, 8'h80, 1'b1, 8'h90, 1'b1, 6'b101110);
        // Reset two beats into a src1 group, then src0 wins the tie from beat 0.
        add("pre_rst", 1'b1, 2'b11, 1'b1, 8'h80, 1'b1, 8'h91, 1'b1, 6'b101100);
        add("mid_rst", 1'b0, 2'b11, 1'b1, 8'h80, 1'b1, 8'h92, 1'b1, 6'b000000);
        for (int k = 0; k < 4; k++)
            add("post_rst", 1'b1, 2'b11, 1'b1, 8'(8'ha0 + k), 1'b1, 8'hb0, 1'b1,
                {4'b1100, 1'(k == 0), 1'(k == 3)});
        // Both masked in IDLE: no grant at all.
        add("masked", 1'b1, 2'b00, 1'b1, 8'ha4, 1'b1, 8'hb4, 1'b1, 6'b000000);
        add("unmask", 1'b1, 2'b11, 1'b1, 8'ha5, 1'b1, 8'hb5, 1'b1, 6'b101110);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstn   = vecs[i].rstn;
            src_en = vecs[i].en;
            v0     = vecs[i].v0;
            d0     = {{(IW-8){1'b0}}, vecs[i].d0};
            v1     = vecs[i].v1;
            d1     = {{(IW-8){1'b0}}, vecs[i].d1};
            prdy   = vecs[i].prdy;
            #1;
            act      = {opvld, p0, p1, osrc, osop, oeop};
            exp_data = vecs[i].exp[2] ? d1 : d0;
            n_checks++;
            if (act === vecs[i].exp) begin
                n_pass++;
            end else begin
                $display("FAIL row %0d %s: got ctl=%b, want ctl=%b",
                         i, vecs[i].tag, act, vecs[i].exp);
            end
            n_checks++;
            if (odata === exp_data) begin
                n_pass++;
            end else begin
                $display("FAIL row %0d %s: got data=%h, want data=%h",
                         i, vecs[i].tag, odata[7:0], exp_data[7:0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass !== n_checks) begin
            $display("FAIL summary: got %0d passing, want %0d", n_pass, n_checks);
            $fatal(1);
        end
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
